// File: rtl/tile_asm_pkg.sv
// Shared definitions for the tile assembler.
// Provides width-derivation helpers (pixel, column, tile, column-counter widths),
// the runtime clamp applied to the configured tile width, and the bank selector type.
package tile_asm_pkg;

    localparam int DEF_PIX_WIDTH = 16;
    localparam int DEF_NUM_CH    = 2;
    localparam int DEF_TILE_ROWS = 6;
    localparam int DEF_TILE_COLS = 6;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_e;

    function automatic int pix_w(input int pix_width, input int num_ch);
        return pix_width * num_ch;
    endfunction

    function automatic int col_w(input int pix_bits, input int tile_rows);
        return pix_bits * tile_rows;
    endfunction

    function automatic int tile_w(input int col_bits, input int tile_cols);
        return col_bits * tile_cols;
    endfunction

    function automatic int cnt_w(input int tile_cols);
        return $clog2(tile_cols + 1);
    endfunction

    // A width of 0 or anything wider than the storage means "use the full tile".
    function automatic int clamp_cols(input int cols, input int max_cols);
        return (cols == 0 || cols > max_cols) ? max_cols : cols;
    endfunction

endpackage

// File: rtl/tile_assembler_if.sv
// Bus bundle between the column producer and the tile consumer.
// master: producer/consumer side (drives columns, cfg, flush, tile_ready).
// slave : the assembler (drives col_ready, tile_valid, tile_data, tile_cols).
interface tile_assembler_if #(
    parameter int PIX_WIDTH = 16,
    parameter int NUM_CH    = 2,
    parameter int TILE_ROWS = 6,
    parameter int TILE_COLS = 6
);
    import tile_asm_pkg::*;

    localparam int COL_W  = col_w(pix_w(PIX_WIDTH, NUM_CH), TILE_ROWS);
    localparam int TILE_W = tile_w(COL_W, TILE_COLS);
    localparam int CNT_W  = cnt_w(TILE_COLS);

    logic [CNT_W-1:0]  cfg_cols;
    logic              flush;
    logic              col_valid;
    logic              col_ready;
    logic [COL_W-1:0]  col_data;
    logic              tile_valid;
    logic              tile_ready;
    logic [TILE_W-1:0] tile_data;
    logic [CNT_W-1:0]  tile_cols;

    modport master (
        output cfg_cols, flush, col_valid, col_data, tile_ready,
        input  col_ready, tile_valid, tile_data, tile_cols
    );

    modport slave (
        input  cfg_cols, flush, col_valid, col_data, tile_ready,
        output col_ready, tile_valid, tile_data, tile_cols
    );

endinterface

// File: rtl/tile_asm_bank.sv
// One ping-pong bank: TILE_COLS column registers, full flag and column count.
// Ports: clk_i/rst_i (async active-low), wr/wr_idx/wr_data column write,
// close/close_cnt mark the bank full with its valid column count, free clears full.
// data presents the stored columns column-major, columns >= count forced to zero.
module tile_asm_bank
    import tile_asm_pkg::*;
#(
    parameter int COL_W     = 192,
    parameter int TILE_COLS = 6,
    parameter int CNT_W     = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr,
    input  logic [CNT_W-1:0]           wr_idx,
    input  logic [COL_W-1:0]           wr_data,
    input  logic                       close,
    input  logic [CNT_W-1:0]           close_cnt,
    input  logic                       free,
    output logic                       full,
    output logic [CNT_W-1:0]           count,
    output logic [tile_w(COL_W, TILE_COLS)-1:0] data
);

    logic [TILE_COLS-1:0][COL_W-1:0] cols;

    // Storage is never cleared; stale columns are hidden by the count mask.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < TILE_COLS; c++) begin
            if (wr && wr_idx == CNT_W'(c)) cols[c] <= wr_data;
        end
    end

    // A bank is never freed while it is being closed (it is the write bank then).
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            full  <= 1'b0;
            count <= '0;
        end else if (close) begin
            full  <= 1'b1;
            count <= close_cnt;
        end else if (free) begin
            full  <= 1'b0;
        end
    end

    always_comb begin
        data = '0;
        for (int c = 0; c < TILE_COLS; c++) begin
            if (c < int'(count)) data[c*COL_W +: COL_W] = cols[c];
        end
    end

endmodule

// File: rtl/tile_assembler.sv
// Column-to-tile assembler with ping-pong banking.
// Ports: clk_i (rising edge), rst_i (async active-low), bus (tile_assembler_if.slave):
//   cfg_cols/flush control, col_valid/col_ready/col_data column intake,
//   tile_valid/tile_ready/tile_data/tile_cols tile output.
// Build option: TILE_ASM_TRANSPOSE_EN defined -> row-major tile_data packing,
// otherwise column-major.
module tile_assembler
    import tile_asm_pkg::*;
#(
    parameter int PIX_WIDTH = DEF_PIX_WIDTH,
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int TILE_ROWS = DEF_TILE_ROWS,
    parameter int TILE_COLS = DEF_TILE_COLS
) (
    input  logic           clk_i,
    input  logic           rst_i,
    tile_assembler_if.slave bus
);

    localparam int PIX_W  = pix_w(PIX_WIDTH, NUM_CH);
    localparam int COL_W  = col_w(PIX_W, TILE_ROWS);
    localparam int TILE_W = tile_w(COL_W, TILE_COLS);
    localparam int CNT_W  = cnt_w(TILE_COLS);

    bank_e                  wr_sel, rd_sel;
    logic [CNT_W-1:0]       wr_col, wr_col_inc, tile_cfg, cfg_eff, close_cnt;
    logic [1:0]             full;
    logic [1:0][CNT_W-1:0]  count;
    logic [1:0][TILE_W-1:0] bank_data;
    logic [TILE_W-1:0]      cm_data, tile_out;
    logic                   accept, flush_hit, close, free;

    assign bus.col_ready = !full[wr_sel];
    assign accept        = bus.col_valid & bus.col_ready;
    assign wr_col_inc    = wr_col + CNT_W'(1);

    // The first column of a tile picks up the width; later columns use the latched one.
    assign cfg_eff   = (wr_col == '0) ? CNT_W'(clamp_cols(int'(bus.cfg_cols), TILE_COLS))
                                      : tile_cfg;
    // Flush only counts when there is something to close and the write bank is open.
    assign flush_hit = bus.flush & bus.col_ready & (accept | (wr_col != '0));
    assign close     = (accept & (wr_col_inc == cfg_eff)) | flush_hit;
    assign close_cnt = accept ? wr_col_inc : wr_col;
    assign free      = bus.tile_valid & bus.tile_ready;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_sel   <= BANK0;
            rd_sel   <= BANK0;
            wr_col   <= '0;
            tile_cfg <= '0;
        end else begin
            if (accept && wr_col == '0) tile_cfg <= cfg_eff;
            if (close) begin
                wr_sel <= (wr_sel == BANK0) ? BANK1 : BANK0;
                wr_col <= '0;
            end else if (accept) begin
                wr_col <= wr_col_inc;
            end
            if (free) rd_sel <= (rd_sel == BANK0) ? BANK1 : BANK0;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        tile_asm_bank #(
            .COL_W     (COL_W),
            .TILE_COLS (TILE_COLS),
            .CNT_W     (CNT_W)
        ) u_bank (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .wr        (accept && wr_sel == bank_e'(b)),
            .wr_idx    (wr_col),
            .wr_data   (bus.col_data),
            .close     (close && wr_sel == bank_e'(b)),
            .close_cnt (close_cnt),
            .free      (free && rd_sel == bank_e'(b)),
            .full      (full[b]),
            .count     (count[b]),
            .data      (bank_data[b])
        );
    end

    assign cm_data = bank_data[rd_sel];

`ifdef TILE_ASM_TRANSPOSE_EN
    always_comb begin
        tile_out = '0;
        for (int r = 0; r < TILE_ROWS; r++) begin
            for (int c = 0; c < TILE_COLS; c++) begin
                tile_out[(r*TILE_COLS+c)*PIX_W +: PIX_W] = cm_data[(c*TILE_ROWS+r)*PIX_W +: PIX_W];
            end
        end
    end
`else
    assign tile_out = cm_data;
`endif

    assign bus.tile_valid = full[rd_sel];
    assign bus.tile_cols  = count[rd_sel];
    assign bus.tile_data  = tile_out;

endmodule

// File: tb/tb_tile_assembler.sv
// Scoreboard bench for tile_assembler: the driver keeps a column-list model of the
// open tile and queues each expected finished tile; a separate monitor pops and
// compares whenever the DUT hands a tile over.
module tb_tile_assembler;

    localparam int PIX_WIDTH = 16;
    localparam int NUM_CH    = 2;
    localparam int TILE_ROWS = 6;
    localparam int TILE_COLS = 6;
    localparam int PIX_W     = PIX_WIDTH * NUM_CH;
    localparam int COL_W     = PIX_W * TILE_ROWS;
    localparam int TILE_W    = COL_W * TILE_COLS;
    localparam int CNT_W     = 3;

    typedef struct {
        logic [TILE_W-1:0] data;
        int                cols;
    } tile_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    tile_assembler_if #(
        .PIX_WIDTH (PIX_WIDTH),
        .NUM_CH    (NUM_CH),
        .TILE_ROWS (TILE_ROWS),
        .TILE_COLS (TILE_COLS)
    ) bus ();

    tile_assembler #(
        .PIX_WIDTH (PIX_WIDTH),
        .NUM_CH    (NUM_CH),
        .TILE_ROWS (TILE_ROWS),
        .TILE_COLS (TILE_COLS)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    tile_t exp_q[$];
    int closed = 0, taken = 0, taken_base = 0, n_seen = 0;
    logic [COL_W-1:0] open_cols [TILE_COLS];
    int n_open = 0, tcfg = TILE_COLS;
    bit last_acc = 0;

    task automatic chk(input string name, input logic [TILE_W-1:0] act, input logic [TILE_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int clampc(input logic [CNT_W-1:0] v);
        return (v == 0 || int'(v) > TILE_COLS) ? TILE_COLS : int'(v);
    endfunction

    function automatic int pix_pos(input int r, input int c);
`ifdef TILE_ASM_TRANSPOSE_EN
        return r * TILE_COLS + c;
`else
        return c * TILE_ROWS + r;
`endif
    endfunction

    function automatic logic [TILE_W-1:0] pack_tile(input int n);
        logic [TILE_W-1:0] t = '0;
        for (int c = 0; c < n; c++)
            for (int r = 0; r < TILE_ROWS; r++)
                t[pix_pos(r, c)*PIX_W +: PIX_W] = open_cols[c][r*PIX_W +: PIX_W];
        return t;
    endfunction

    function automatic logic [COL_W-1:0] rand_col();
        logic [COL_W-1:0] d;
        for (int i = 0; i < COL_W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [COL_W-1:0] idx_col(input int c);
        logic [COL_W-1:0] d;
        for (int r = 0; r < TILE_ROWS; r++) d[r*PIX_W +: PIX_W] = {16'(c), 16'(r)};
        return d;
    endfunction

    // One clock: drive at posedge+1, check and update the model at negedge.
    task automatic cyc(input bit v, input logic [COL_W-1:0] d, input bit fl,
                       input logic [CNT_W-1:0] cfg, input bit tr);
        int pend;
        bit erdy, acc, cls;
        bus.col_valid  = v;
        bus.col_data   = d;
        bus.flush      = fl;
        bus.cfg_cols   = cfg;
        bus.tile_ready = tr;
        @(negedge clk);
        pend = closed - (taken - taken_base);
        erdy = (pend < 2);
        chk("col_ready", TILE_W'(bus.col_ready), TILE_W'(erdy));
        chk("tile_valid", TILE_W'(bus.tile_valid), TILE_W'(pend > 0));
        acc = v && erdy;
        if (acc) begin
            if (n_open == 0) tcfg = clampc(cfg);
            open_cols[n_open] = d;
            n_open++;
        end
        cls = (acc && n_open == tcfg) || (fl && erdy && n_open > 0);
        if (cls) begin
            exp_q.push_back('{data: pack_tile(n_open), cols: n_open});
            closed++;
            n_open = 0;
        end
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [COL_W-1:0] d, input logic [CNT_W-1:0] cfg, input bit tr);
        int g = 0;
        do begin
            cyc(1'b1, d, 1'b0, cfg, tr);
            g++;
        end while (!last_acc && g < 50);
        if (!last_acc) chk("send_timeout", TILE_W'(last_acc), TILE_W'(1));
    endtask

    task automatic idle(input int n, input bit tr);
        repeat (n) cyc(1'b0, '0, 1'b0, 3'd6, tr);
    endtask

    // Monitor: pops the next expected tile on every output handshake.
    initial begin
        tile_t t;
        int p;
        forever begin
            @(negedge clk);
            #1;
            if (rst && bus.tile_valid && bus.tile_ready) begin
                if (exp_q.size() == 0) begin
                    chk("tile_unexpected", TILE_W'(bus.tile_valid), TILE_W'(0));
                end else begin
                    t = exp_q.pop_front();
                    chk("tile_cols", TILE_W'(bus.tile_cols), TILE_W'(t.cols));
                    chk("tile_data", bus.tile_data, t.data);
                    if (n_seen == 0) begin
                        p = pix_pos(2, 3) * PIX_W;
                        chk("pixel_r2_c3", TILE_W'(bus.tile_data[p +: PIX_W]), TILE_W'({16'd3, 16'd2}));
                    end
                end
                n_seen++;
                taken++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.col_valid  = 1'b0;
        bus.col_data   = '0;
        bus.flush      = 1'b0;
        bus.cfg_cols   = 3'd6;
        bus.tile_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tile_valid", TILE_W'(bus.tile_valid), TILE_W'(0));
        chk("rst_col_ready", TILE_W'(bus.col_ready), TILE_W'(1));
        chk("rst_tile_cols", TILE_W'(bus.tile_cols), TILE_W'(0));
        chk("rst_tile_data", bus.tile_data, TILE_W'(0));
        rst = 1'b1;

        // Indexed pixels, full-width tile.
        for (int c = 0; c < 6; c++) send(idx_col(c), 3'd6, 1'b1);
        idle(3, 1'b1);

        // Twelve back-to-back columns with an always-ready consumer.
        for (int k = 0; k < 12; k++) cyc(1'b1, rand_col(), 1'b0, 3'd6, 1'b1);
        idle(3, 1'b1);

        // Stalled consumer: both banks fill, intake stops, then resumes.
        for (int k = 0; k < 12; k++) send(rand_col(), 3'd6, 1'b0);
        begin
            logic [COL_W-1:0] hold;
            hold = rand_col();
            repeat (4) cyc(1'b1, hold, 1'b0, 3'd6, 1'b0);
            send(hold, 3'd6, 1'b1);
        end
        for (int k = 0; k < 7; k++) send(rand_col(), 3'd6, 1'b1);
        cyc(1'b0, '0, 1'b1, 3'd6, 1'b1);
        idle(4, 1'b1);

        // Narrow tiles and flush.
        for (int k = 0; k < 3; k++) send(rand_col(), 3'd4, 1'b1);
        cyc(1'b1, rand_col(), 1'b1, 3'd4, 1'b1);
        for (int k = 0; k < 2; k++) send(rand_col(), 3'd4, 1'b1);
        cyc(1'b0, '0, 1'b1, 3'd4, 1'b1);
        cyc(1'b0, '0, 1'b1, 3'd4, 1'b1);
        idle(3, 1'b1);

        // Out-of-range widths and a mid-tile width change.
        for (int k = 0; k < 6; k++) send(rand_col(), 3'd0, 1'b1);
        for (int k = 0; k < 6; k++) send(rand_col(), 3'd7, 1'b1);
        for (int k = 0; k < 2; k++) send(rand_col(), 3'd3, 1'b1);
        send(rand_col(), 3'd5, 1'b1);
        for (int k = 0; k < 5; k++) send(rand_col(), 3'd5, 1'b1);
        idle(3, 1'b1);

        // Random traffic.
        for (int k = 0; k < 600; k++)
            cyc(($urandom % 4) != 0, rand_col(), ($urandom % 8) == 0,
                CNT_W'($urandom % 8), ($urandom % 3) != 0);

        cyc(1'b0, '0, 1'b1, 3'd6, 1'b1);
        idle(8, 1'b1);
        chk("drain_empty", TILE_W'(exp_q.size()), TILE_W'(0));

        // Reset in the middle of a tile.
        for (int k = 0; k < 3; k++) send(rand_col(), 3'd6, 1'b0);
        bus.col_valid = 1'b0;
        rst = 1'b0;
        n_open = 0;
        exp_q.delete();
        closed = 0;
        taken_base = taken;
        @(negedge clk);
        chk("midrst_tile_valid", TILE_W'(bus.tile_valid), TILE_W'(0));
        chk("midrst_col_ready", TILE_W'(bus.col_ready), TILE_W'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 6; k++) send(rand_col(), 3'd6, 1'b1);
        idle(3, 1'b1);
        chk("post_rst_empty", TILE_W'(exp_q.size()), TILE_W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
